ln_var_acc_seq: RTL and testbench

//  Loop sequencer for the LayerNorm stage-1 variance accumulator. Takes one layer config and

---
 rtl/ln_var_acc_seq_if.sv | 39 +++
 rtl/ln_var_acc_seq.sv | 153 +++++++++++++++
 tb/tb_ln_var_acc_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ln_var_acc_seq_if.sv
// Beat stream between the variance-accumulator sequencer, its upstream source and the accumulator.
// Handshake: a beat transfers in any cycle where in_vld & in_rdy; the source holds in_vld and its data
// until accepted, and in_rdy may be dropped without notice. acc_dat_vld is exactly that transfer qualifier.
interface ln_var_acc_seq_if #(
    parameter int RECIP_W = 33
) ();
    logic               in_vld;
    logic               in_rdy;
    logic               acc_dat_vld;
    logic               acc_stripe_end;
    logic               acc_ch_max_now;
    logic               acc_ch_stripe_end;
    logic [RECIP_W-1:0] acc_recip_ch;
    logic               acc_out_vld;

    // Sequencer side.
    modport master (
        input  in_vld,
        input  acc_out_vld,
        output in_rdy,
        output acc_dat_vld,
        output acc_stripe_end,
        output acc_ch_max_now,
        output acc_ch_stripe_end,
        output acc_recip_ch
    );

    // Upstream source plus accumulator side.
    modport slave (
        output in_vld,
        output acc_out_vld,
        input  in_rdy,
        input  acc_dat_vld,
        input  acc_stripe_end,
        input  acc_ch_max_now,
        input  acc_ch_stripe_end,
        input  acc_recip_ch
    );
endinterface

// File: rtl/ln_var_acc_seq.sv
// LayerNorm stage-1 variance accumulator loop sequencer: forwards beats, generates loop-end tags,
// spaces out short stripes and reports done after the accumulator drains.
module ln_var_acc_seq #(
    parameter int LOG2_TOUT  = 5,
    parameter int CNT_W      = 16,
    parameter int RECIP_W    = 33,  // 2*MAX_DAT_DW+1 with 16-bit data
    parameter int OUT_LAT    = 4,
    parameter int MIN_STRIPE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LOG2_TOUT:0]   cfg_stripe_len,
    input  logic [CNT_W-1:0]     cfg_ch_groups,
    input  logic [CNT_W-1:0]     cfg_tiles,
    input  logic [RECIP_W-1:0]   cfg_recip_ch,
    ln_var_acc_seq_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 cnt_err,
    output logic [2:0]           dbg_state
);
    localparam int SL_W   = LOG2_TOUT + 1;
    localparam int OUT_W  = CNT_W + LOG2_TOUT + 1;
    localparam int WAIT_W = 8;
    localparam logic [SL_W-1:0]   TOUT   = {1'b1, {LOG2_TOUT{1'b0}}};
    localparam logic [SL_W-1:0]   MIN_SL = SL_W'(MIN_STRIPE);
    localparam logic [WAIT_W-1:0] MIN_W  = WAIT_W'(MIN_STRIPE);
    localparam logic [WAIT_W-1:0] LAT_W  = WAIT_W'(OUT_LAT);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [SL_W-1:0]    stripe_len_q;
    logic [CNT_W-1:0]   ch_groups_q, tiles_q;
    logic [RECIP_W-1:0] recip_q;
    logic [SL_W-1:0]    beat_cnt_q;
    logic [CNT_W-1:0]   grp_cnt_q, tile_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_nxt, exp_cnt;
    logic               cnt_err_q, cfg_err_q;

    logic cfg_ok, launch, beat, last_beat, last_grp, last_tile;
    logic stripe_end, ch_stripe_end, final_beat, short_stripe;

    assign cfg_ok = (cfg_stripe_len != '0) && (cfg_stripe_len <= TOUT) &&
                    (cfg_ch_groups != '0) && (cfg_tiles != '0);
    assign launch = (state_q == S_IDLE) && start && cfg_ok;

    assign bus.in_rdy      = (state_q == S_RUN);
    assign beat            = bus.in_vld && bus.in_rdy;
    assign bus.acc_dat_vld = beat;

    assign last_beat     = beat_cnt_q == stripe_len_q - 1'b1;
    assign last_grp      = grp_cnt_q == ch_groups_q - 1'b1;
    assign last_tile     = tile_cnt_q == tiles_q - 1'b1;
    assign stripe_end    = beat && last_beat;
    assign ch_stripe_end = stripe_end && last_grp;
    assign final_beat    = ch_stripe_end && last_tile;
    assign short_stripe  = stripe_len_q < MIN_SL;

    assign bus.acc_stripe_end    = stripe_end;
    assign bus.acc_ch_max_now    = beat && last_grp;
    assign bus.acc_ch_stripe_end = ch_stripe_end;
    assign bus.acc_recip_ch      = recip_q;

    // Result beats arriving in the last drain cycle still count toward the final tally.
    assign out_cnt_nxt = out_cnt_q + OUT_W'(bus.acc_out_vld);
    assign exp_cnt     = OUT_W'(tiles_q) * OUT_W'(stripe_len_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN: begin
                if (final_beat)                      state_d = S_DRAIN;
                else if (stripe_end && short_stripe) state_d = S_GAP;
            end
            S_GAP:   if (wait_cnt_q == '0) state_d = S_RUN;
            S_DRAIN: if (wait_cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stripe_len_q <= '0;
            ch_groups_q  <= '0;
            tiles_q      <= '0;
            recip_q      <= '0;
            beat_cnt_q   <= '0;
            grp_cnt_q    <= '0;
            tile_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            out_cnt_q    <= '0;
            cnt_err_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;

            if (launch) begin
                stripe_len_q <= cfg_stripe_len;
                ch_groups_q  <= cfg_ch_groups;
                tiles_q      <= cfg_tiles;
                recip_q      <= cfg_recip_ch;
                beat_cnt_q   <= '0;
                grp_cnt_q    <= '0;
                tile_cnt_q   <= '0;
                out_cnt_q    <= '0;
                cnt_err_q    <= 1'b0;
            end else begin
                if (state_q != S_IDLE) out_cnt_q <= out_cnt_nxt;
                if (state_q == S_DRAIN && state_d == S_DONE)
                    cnt_err_q <= (out_cnt_nxt != exp_cnt);
            end

            if (beat) begin
                if (last_beat) begin
                    beat_cnt_q <= '0;
                    if (last_grp) begin
                        grp_cnt_q  <= '0;
                        tile_cnt_q <= last_tile ? '0 : tile_cnt_q + 1'b1;
                    end else begin
                        grp_cnt_q <= grp_cnt_q + 1'b1;
                    end
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end

            // One shared down-counter times both the short-stripe bubble and the drain wait.
            if (state_q == S_RUN && state_d == S_GAP)
                wait_cnt_q <= MIN_W - WAIT_W'(stripe_len_q) - 1'b1;
            else if (state_q == S_RUN && state_d == S_DRAIN)
                wait_cnt_q <= LAT_W;
            else if ((state_q == S_GAP || state_q == S_DRAIN) && wait_cnt_q != '0)
                wait_cnt_q <= wait_cnt_q - 1'b1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign cnt_err   = cnt_err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_ln_var_acc_seq.sv
// Scoreboard bench for ln_var_acc_seq: expected tags queued per layer, checked on each accepted beat.
module tb_ln_var_acc_seq;
    localparam int RW      = 33;
    localparam int OUT_LAT = 4;

    logic          clk, rst_n, start;
    logic [5:0]    cfg_stripe_len;
    logic [15:0]   cfg_ch_groups, cfg_tiles;
    logic [RW-1:0] cfg_recip_ch;
    logic          busy, done, cfg_err, cnt_err;
    logic [2:0]    dbg_state;
    logic [OUT_LAT-1:0] acc_pipe;
    logic          mask_out, mon_en;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    ln_var_acc_seq_if #(.RECIP_W(RW)) bus ();

    ln_var_acc_seq #(.RECIP_W(RW), .OUT_LAT(OUT_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_stripe_len(cfg_stripe_len), .cfg_ch_groups(cfg_ch_groups),
        .cfg_tiles(cfg_tiles), .cfg_recip_ch(cfg_recip_ch),
        .bus(bus),
        .busy(busy), .done(done), .cfg_err(cfg_err), .cnt_err(cnt_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator model: one result beat OUT_LAT cycles after each ch_max_now beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_pipe <= '0;
        else        acc_pipe <= {acc_pipe[OUT_LAT-2:0], bus.acc_dat_vld & bus.acc_ch_max_now};
    end
    assign bus.acc_out_vld = acc_pipe[OUT_LAT-1] & ~mask_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.acc_dat_vld) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
                else check_eq("tags", {bus.acc_stripe_end, bus.acc_ch_max_now, bus.acc_ch_stripe_end},
                              exp_q.pop_front());
            end else if (busy) begin
                check_eq("tag_idle", {bus.acc_stripe_end, bus.acc_ch_max_now, bus.acc_ch_stripe_end}, 0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdy"},   bus.in_rdy, 0);
        check_eq({tag, "_vld"},   bus.acc_dat_vld, 0);
        check_eq({tag, "_tags"},  {bus.acc_stripe_end, bus.acc_ch_max_now, bus.acc_ch_stripe_end}, 0);
        check_eq({tag, "_recip"}, bus.acc_recip_ch, 0);
        check_eq({tag, "_flags"}, {busy, done, cfg_err, cnt_err}, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    // Driver: one layer. exp_span=0 skips the beat-span check; glitch_at/abort_at=0 disables them.
    task automatic run_layer(input int sl, input int cg, input int tl, input int pct,
                             input int exp_span, input int glitch_at, input int abort_at,
                             input logic exp_err, input logic [RW-1:0] recip);
        int total, beats, cyc, first_cyc, last_cyc, lat;
        logic got_beat;
        total = sl * cg * tl;
        for (int t = 0; t < tl; t++)
            for (int g = 0; g < cg; g++)
                for (int b = 0; b < sl; b++)
                    exp_q.push_back({b == sl - 1, g == cg - 1, (b == sl - 1) && (g == cg - 1)});

        @(posedge clk); #1;
        start = 1'b1; cfg_stripe_len = 6'(sl); cfg_ch_groups = 16'(cg);
        cfg_tiles = 16'(tl); cfg_recip_ch = recip;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("recip_loaded", bus.acc_recip_ch, recip);
        check_eq("cnt_err_cleared", cnt_err, 0);

        beats = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
        bus.in_vld = ($urandom_range(0, 99) < pct);
        while (beats < total && cyc < 2000) begin
            @(negedge clk);
            got_beat = bus.in_vld && bus.in_rdy;
            if (got_beat) begin
                beats++;
                if (beats == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (abort_at > 0 && beats == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("abort");
                exp_q.delete();
                bus.in_vld = 1'b0;
                @(posedge clk); #3 rst_n = 1'b1;
                return;
            end
            if (beats == total) break;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (glitch_at > 0 && beats == glitch_at && got_beat) begin
                start = 1'b1; cfg_stripe_len = 6'd7; cfg_ch_groups = 16'd5; cfg_recip_ch = ~recip;
            end
            bus.in_vld = ($urandom_range(0, 99) < pct);
        end
        check_eq("beats_accepted", beats, total);
        if (exp_span > 0) check_eq("beat_span", last_cyc - first_cyc + 1, exp_span);

        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            bus.in_vld = 1'b0;
            lat++;
            @(negedge clk);
            if (done) break;
        end
        check_eq("done_latency", lat, OUT_LAT + 2);
        check_eq("busy_in_done", busy, 1);
        check_eq("cnt_err", cnt_err, exp_err);
        check_eq("recip_held", bus.acc_recip_ch, recip);
        check_eq("sb_left", exp_q.size(), 0);
        @(negedge clk);
        check_eq("done_pulse", {done, busy}, 0);
    endtask

    initial begin
        int found;
        rst_n = 1'b0; start = 1'b0; mon_en = 1'b0; mask_out = 1'b0;
        cfg_stripe_len = '0; cfg_ch_groups = '0; cfg_tiles = '0; cfg_recip_ch = '0;
        bus.in_vld = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;

        // 1: continuous stream, with a start pulse while busy that must be ignored
        run_layer(4, 3, 2, 100, 24, 10, 0, 1'b0, 33'h0_1234_5678);
        // 2: single-beat stripes need one bubble each
        run_layer(1, 2, 3, 100, 11, 0, 0, 1'b0, 33'h1_0000_0001);
        // 3: random valid
        run_layer(32, 4, 1, 50, 0, 0, 0, 1'b0, 33'h0_0AAA_5555);

        // 4: illegal configurations
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            start = 1'b1; cfg_stripe_len = 6'd4; cfg_ch_groups = 16'd2; cfg_tiles = 16'd2;
            if (k == 0) cfg_ch_groups = 16'd0;
            if (k == 1) cfg_stripe_len = 6'd0;
            if (k == 2) cfg_stripe_len = 6'd33;
            if (k == 3) cfg_tiles = 16'd0;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check_eq("cfg_err_pulse", cfg_err, 1);
            check_eq("cfg_err_busy", busy, 0);
            @(negedge clk);
            check_eq("cfg_err_clear", cfg_err, 0);
        end

        // 5: accumulator loses one result beat
        fork
            run_layer(8, 1, 1, 100, 8, 0, 0, 1'b1, 33'h0_0000_0F0F);
            begin
                found = 0;
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (acc_pipe[OUT_LAT-1]) begin found = 1; break; end
                end
                check_eq("mask_found", found, 1);
                mask_out = 1'b1;
                @(posedge clk); #1 mask_out = 1'b0;
            end
        join
        run_layer(2, 1, 1, 100, 2, 0, 0, 1'b0, 33'h0_0000_0F0F);

        // 6: reset mid-layer, then a clean rerun
        run_layer(4, 3, 2, 100, 0, 0, 5, 1'b0, 33'h0_0000_7777);
        run_layer(4, 3, 2, 100, 24, 0, 0, 1'b0, 33'h0_0000_7777);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
